// File: rtl/seven_seg_reader.sv
// Seven-segment bus reader: samples a multiplexed active-low segment/select bus,
// waits for a stable pattern, and decodes it back into per-digit hex nibbles.
module seven_seg_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned IdxW         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic                  bad_pattern,
  output logic [IdxW-1:0]       bad_digit
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {StTrack, StLocked} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [6:0]          seg_q, seg_prev_q;
  logic [DIGITS-1:0]   an_q, an_prev_q;

  logic [DIGITS-1:0]   sel;
  logic                sel_legal;
  logic [IdxW-1:0]     sel_idx;
  logic                changed;
  logic                accept;
  logic [4:0]          dec;

  logic [4*DIGITS-1:0] value_d;
  logic [DIGITS-1:0]   valid_d;
  logic                update_d;
  logic                bad_d;
  logic [IdxW-1:0]     bad_digit_d;

  // Returns {legal, nibble}; legal=0 for blank and unknown patterns.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Select decode: legal only when exactly one select line is driven low.
  always_comb begin
    sel       = ~an_q;
    sel_legal = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
    sel_idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) sel_idx = IdxW'(i);
    end
    changed = ({seg_q, an_q} != {seg_prev_q, an_prev_q});
  end

  // Stability FSM: count identical legal samples, lock once accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StTrack: begin
        if (changed || !sel_legal) cnt_d = '0;
        else                       cnt_d = cnt_q + CntW'(1);
      end
      StLocked: begin
        if (changed || !sel_legal) begin
          cnt_d   = '0;
          state_d = StTrack;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StTrack;
      end
    endcase
    // With STABLE_CYCLES=1 a freshly changed legal sample is accepted at once.
    if (sel_legal && (state_d == StTrack) && (cnt_d == CntMax)) begin
      accept  = 1'b1;
      state_d = StLocked;
    end
  end

  // Output next-state: only the selected digit is touched on acceptance.
  always_comb begin
    value_d     = value;
    valid_d     = digit_valid;
    update_d    = 1'b0;
    bad_d       = 1'b0;
    bad_digit_d = bad_digit;
    dec         = decode(seg_q);
    if (accept) begin
      if (dec[4]) begin
        if (!digit_valid[sel_idx] || (value[4*int'(sel_idx) +: 4] != dec[3:0])) begin
          update_d = 1'b1;
        end
        value_d[4*int'(sel_idx) +: 4] = dec[3:0];
        valid_d[sel_idx]              = 1'b1;
      end else begin
        valid_d[sel_idx] = 1'b0;
        if (seg_q != 7'h7F) begin
          bad_d       = 1'b1;
          bad_digit_d = sel_idx;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= '1;
      an_q        <= '1;
      seg_prev_q  <= '1;
      an_prev_q   <= '1;
      cnt_q       <= '0;
      state_q     <= StTrack;
      value       <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      bad_pattern <= 1'b0;
      bad_digit   <= '0;
    end else begin
      seg_q       <= seg_n;
      an_q        <= an_n;
      seg_prev_q  <= seg_q;
      an_prev_q   <= an_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      value       <= value_d;
      digit_valid <= valid_d;
      update      <= update_d;
      bad_pattern <= bad_d;
      bad_digit   <= bad_digit_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Randomised and directed bench for seven_seg_reader with a run-length reference model.
module tb_seven_seg_reader;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        update;
  logic        bad_pattern;
  logic [1:0]  bad_digit;

  int vectors = 0;
  int errors  = 0;

  seven_seg_reader #(
    .DIGITS        (4),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .value       (value),
    .digit_valid (digit_valid),
    .update      (update),
    .bad_pattern (bad_pattern),
    .bad_digit   (bad_digit)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [6:0] pats [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] m_val [4];
  logic [3:0] m_valid;
  logic       m_upd, m_bad;
  logic [1:0] m_bd;
  int         run;
  logic [6:0] last_seg;
  logic [3:0] last_an;

  function automatic logic [23:0] exp_vec();
    return {m_val[3], m_val[2], m_val[1], m_val[0], m_valid, m_upd, m_bad, m_bd};
  endfunction

  // A pattern is accepted once the same legal input has been applied for STABLE
  // consecutive edges; the decision lands on the following edge.
  task automatic step(input logic [6:0] s, input logic [3:0] a, input logic r);
    int idx;
    int nib;
    seg_n = s;
    an_n  = a;
    rst   = r;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
      m_valid  = 4'h0;
      m_upd    = 1'b0;
      m_bad    = 1'b0;
      m_bd     = 2'd0;
      run      = 0;
      last_seg = 7'h7F;
      last_an  = 4'hF;
    end else begin
      m_upd = 1'b0;
      m_bad = 1'b0;
      if (run == STABLE && $countones(~last_an) == 1) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (!last_an[i]) idx = i;
        nib = -1;
        for (int p = 0; p < 16; p++) if (pats[p] == last_seg) nib = p;
        if (nib >= 0) begin
          if (!m_valid[idx] || m_val[idx] != 4'(nib)) m_upd = 1'b1;
          m_val[idx]   = 4'(nib);
          m_valid[idx] = 1'b1;
        end else begin
          m_valid[idx] = 1'b0;
          if (last_seg != 7'h7F) begin
            m_bad = 1'b1;
            m_bd  = 2'(idx);
          end
        end
      end
      if (s == last_seg && a == last_an) begin
        if (run < 1000) run++;
      end else begin
        run      = 1;
        last_seg = s;
        last_an  = a;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(7'h7F, 4'hF, 1'b1);
    step(7'h7F, 4'hF, 1'b1);
    vectors++;
    if ({value, digit_valid, update, bad_pattern, bad_digit} !== 24'h0) begin
      errors++;
      $display("FAIL reset: got %h want %h", {value, digit_valid, update, bad_pattern, bad_digit},
               24'h0);
    end
  endtask

  task automatic test_single_digit();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(7'h24, 4'b1110, 1'b0);
      if (update) pulses++;
      vectors++;
      if ({value, digit_valid, update, bad_pattern, bad_digit} !== exp_vec()) begin
        errors++;
        $display("FAIL single_digit cyc %0d: got %h want %h", i,
                 {value, digit_valid, update, bad_pattern, bad_digit}, exp_vec());
      end
      if (i == 4) begin
        vectors++;
        if (update !== 1'b1 || value[3:0] !== 4'h2 || digit_valid !== 4'b0001) begin
          errors++;
          $display("FAIL single_digit_latency: got upd=%b val=%h vld=%b want 1 2 0001",
                   update, value[3:0], digit_valid);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL single_digit_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_scan(input bit rescan);
    logic [6:0] sp [4] = '{7'h30, 7'h12, 7'h08, 7'h0E};
    int pulses = 0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 6; c++) begin
        step(sp[d], ~(4'b0001 << d), 1'b0);
        if (update) pulses++;
        vectors++;
        if ({value, digit_valid, update, bad_pattern, bad_digit} !== exp_vec()) begin
          errors++;
          $display("FAIL scan d%0d c%0d: got %h want %h", d, c,
                   {value, digit_valid, update, bad_pattern, bad_digit}, exp_vec());
        end
      end
    end
    vectors++;
    if (value !== 16'hFA53 || digit_valid !== 4'hF || pulses != (rescan ? 0 : 4)) begin
      errors++;
      $display("FAIL scan_result rescan=%0d: got val=%h vld=%h pulses=%0d want FA53 F %0d",
               rescan, value, digit_valid, pulses, rescan ? 0 : 4);
    end
  endtask

  task automatic test_short_hold();
    for (int c = 0; c < 6; c++) begin
      step((c < 3) ? 7'h79 : 7'h24, 4'b1101, 1'b0);
      vectors++;
      if ({value, digit_valid, update, bad_pattern, bad_digit} !== exp_vec()) begin
        errors++;
        $display("FAIL short_hold c%0d: got %h want %h", c,
                 {value, digit_valid, update, bad_pattern, bad_digit}, exp_vec());
      end
      vectors++;
      if (update !== 1'b0 || value !== 16'hFA53 || digit_valid !== 4'hF) begin
        errors++;
        $display("FAIL short_hold_stable c%0d: got upd=%b val=%h vld=%h want 0 FA53 F", c,
                 update, value, digit_valid);
      end
    end
  endtask

  task automatic test_bad_pattern();
    int bads = 0;
    for (int c = 0; c < 6; c++) begin
      step(7'h55, 4'b1011, 1'b0);
      if (bad_pattern) bads++;
      vectors++;
      if ({value, digit_valid, update, bad_pattern, bad_digit} !== exp_vec()) begin
        errors++;
        $display("FAIL bad_pattern c%0d: got %h want %h", c,
                 {value, digit_valid, update, bad_pattern, bad_digit}, exp_vec());
      end
    end
    vectors++;
    if (bads != 1 || bad_digit !== 2'd2 || digit_valid[2] !== 1'b0 || value[11:8] !== 4'hA) begin
      errors++;
      $display("FAIL bad_pattern_result: got bads=%0d bd=%0d vld2=%b nib=%h want 1 2 0 A",
               bads, bad_digit, digit_valid[2], value[11:8]);
    end
  endtask

  task automatic test_multi_select_and_blank();
    int pulses = 0;
    for (int c = 0; c < 26; c++) begin
      if (c < 20) step(7'h40, 4'b1100, 1'b0);
      else        step(7'h7F, 4'b1110, 1'b0);
      if (update || bad_pattern) pulses++;
      vectors++;
      if ({value, digit_valid, update, bad_pattern, bad_digit} !== exp_vec()) begin
        errors++;
        $display("FAIL multi_blank c%0d: got %h want %h", c,
                 {value, digit_valid, update, bad_pattern, bad_digit}, exp_vec());
      end
    end
    vectors++;
    if (pulses != 0 || digit_valid !== 4'b1010 || value !== 16'hFA53) begin
      errors++;
      $display("FAIL multi_blank_result: got pulses=%0d vld=%b val=%h want 0 1010 FA53",
               pulses, digit_valid, value);
    end
  endtask

  task automatic test_reset_mid_count();
    for (int c = 0; c < 3; c++) step(7'h40, 4'b1110, 1'b0);
    step(7'h40, 4'b1110, 1'b1);
    vectors++;
    if ({value, digit_valid, update, bad_pattern, bad_digit} !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h", {value, digit_valid, update, bad_pattern,
               bad_digit}, 24'h0);
    end
    for (int c = 1; c <= STABLE + 2; c++) begin
      step(7'h40, 4'b1110, 1'b0);
      vectors++;
      if (update !== (c == STABLE + 1) || digit_valid[0] !== (c >= STABLE + 1)) begin
        errors++;
        $display("FAIL reset_relatch edge %0d: got upd=%b vld0=%b want %b %b", c, update,
                 digit_valid[0], c == STABLE + 1, c >= STABLE + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [3:0] a;
    int hold;
    for (int k = 0; k < 80; k++) begin
      a = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 4'($urandom);
      case ($urandom_range(0, 9))
        0:       s = 7'h7F;
        1, 2:    s = 7'($urandom);
        default: s = pats[$urandom_range(0, 15)];
      endcase
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        step(s, a, ($urandom_range(0, 60) == 0));
        vectors++;
        if ({value, digit_valid, update, bad_pattern, bad_digit} !== exp_vec()) begin
          errors++;
          $display("FAIL random k%0d c%0d seg=%h an=%b: got %h want %h", k, c, s, a,
                   {value, digit_valid, update, bad_pattern, bad_digit}, exp_vec());
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    seg_n = 7'h7F;
    an_n  = 4'hF;
    test_reset();
    test_single_digit();
    test_reset();
    test_scan(1'b0);
    test_scan(1'b1);
    test_short_hold();
    test_bad_pattern();
    test_multi_select_and_blank();
    test_reset_mid_count();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
Inverse of the hex-to-seven-segment encoder. It samples a multiplexed, active-low seven-segment drive bus (segment lines plus one-hot active-low digit selects) and recovers the hex nibble shown on each digit. A pattern is accepted only after it has been stable for a set number of cycles. Used on the bench and on-chip to read back display drivers, and to decode external panel scan lines into registers.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical registered samples required before acceptance (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
seg_n  in  7  active-low segments; bit0=a ... bit6=g
an_n  in  DIGITS  active-low digit select; exactly one bit low = legal scan
value  out  4*DIGITS  decoded nibbles; digit i at [4i+3:4i]
digit_valid  out  DIGITS  1 = digit i holds a decoded legal hex pattern
update  out  1  one-cycle pulse: a digit took a new or changed legal value
bad_pattern  out  1  one-cycle pulse: an accepted pattern is not in the decode table
bad_digit  out  max(1,$clog2(DIGITS))  index of the digit that caused the last bad_pattern; holds its value until the next one

Behaviour:
- Reset (synchronous): value=0, digit_valid=0, update=0, bad_pattern=0, bad_digit=0, sample registers=all-ones (blank/none selected), stability counter=0, accepted flag=0.
- Input stage: seg_n and an_n are registered once per cycle into seg_q and an_q. Inputs are in the clk domain, so there is no synchroniser.
- Stability tracking:
  - If {seg_q, an_q} differs from the previous cycle's value, or an_q is not one-hot-low, then counter=0 and accepted=0.
  - Otherwise, if accepted=0, the counter increments.
  - Acceptance occurs on the edge where the counter reaches STABLE_CYCLES-1. At that edge accepted=1 and the counter holds. No re-acceptance happens until the sample changes.
  - Latency: an input held constant is reflected on the outputs STABLE_CYCLES+1 rising edges after it is first applied.
- Effective FSM states: TRACK (counting), then LOCKED (accepted, waiting for change), then back to TRACK on any change. Illegal select (zero or multiple bits low) forces TRACK with count 0. Such a select is never accepted and raises no error.
- Decode table, seg_n (hex, bit6..0) to nibble: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
- On acceptance for digit i:
  - Legal pattern: value[i] is set to the decoded nibble and digit_valid[i]=1. update pulses only if digit_valid[i] was 0 or the nibble differs from the stored one.
  - Blank pattern 7F: digit_valid[i]=0, value[i] is held, no pulse.
  - Any other pattern: digit_valid[i]=0, value[i] is held, bad_pattern pulses, bad_digit=i.
- update and bad_pattern are mutually exclusive and last exactly one cycle. Other digits' state is never disturbed.
- Reset asserted mid-count discards progress. After reset releases, a stable input needs the full latency again.
- Digits never scanned keep digit_valid=0 indefinitely. There is no timeout.

Test Plan:
- Reset, then an_n=4'b1110 with seg_n=7'h24 held 10 cycles (STABLE_CYCLES=4) → on the 5th edge value[3:0]=2, digit_valid=4'b0001, update pulses once. No further pulses while held.
- Scan digits 0..3 with 0x30, 0x12, 0x08, 0x0E, 6 cycles each → value=16'hFA53, digit_valid=4'hF, exactly 4 update pulses. Rescanning the identical values → no update pulses.
- Digit 1 held 3 cycles, then seg_n changed, then held 3 cycles → never accepted: value, digit_valid and update unchanged.
- Digit 2 with illegal 7'h55 held 6 cycles → bad_pattern pulses once, bad_digit=2, digit_valid[2]=0, value[11:8] keeps its prior nibble.
- an_n=4'b1100 (two digits selected) with 7'h40 held 20 cycles → no acceptance, no pulses. Blank 7'h7F on a valid digit → its valid bit clears with no pulse.
- Assert rst for 1 cycle at count 3 of a stable digit-0 pattern → all outputs 0. Acceptance occurs STABLE_CYCLES+1 edges after rst deasserts.
